// File: rtl/pin_bus_interface.sv
// Pin-side memory bus port: runs one ALE/DS transfer over the TinyTapeout pins per CPU
// request, with a timeout that substitutes fixed read data when no memory answers.
module pin_bus_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rdy,
    output logic       done,
    output logic       err,
    output logic [7:0] bus_addr,
    output logic       bus_ale,
    output logic       bus_ds,
    output logic       bus_rw,
    output logic [7:0] bus_dout,
    output logic [7:0] bus_oe,
    input  logic [7:0] bus_din,
    input  logic       ext_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rw;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    // The counter only advances inside WAIT and WAIT is left as soon as it
    // reaches TIMEOUT_CYCLES, so it can never wrap.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // NOTE: every signal assigned in always_comb gets a default first; a missing
    // branch would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (req)                   w_state_next = S_ADDR;
            S_ADDR: if (!ext_ack)              w_state_next = S_WAIT;
            S_WAIT: if (ext_ack || w_timeout)  w_state_next = S_DONE;
            S_DONE:                            w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw    <= 1'b1;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rw    <= rw;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // Ack takes priority over a timeout landing on the same edge.
                    if (ext_ack) begin
                        if (r_rw) r_rdata <= bus_din;
                    end else if (w_timeout) begin
                        if (r_rw) r_rdata <= TIMEOUT_DATA;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data pins are driven only in WAIT of a write, leaving ADDR and DONE as
    // turnaround cycles with no contention against the memory.
    assign bus_oe   = (r_state == S_WAIT && !r_rw) ? 8'hFF : 8'h00;
    assign bus_ale  = (r_state == S_ADDR);
    assign bus_ds   = (r_state == S_WAIT);
    assign bus_addr = r_addr;
    assign bus_rw   = r_rw;
    assign bus_dout = r_wdata;
    assign rdy      = (r_state == S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_pin_bus_interface.sv
// Directed bench for pin_bus_interface: expected completions are queued as each
// transfer is launched and popped when done pulses.
module tb_pin_bus_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdy;
    logic       done;
    logic       err;
    logic [7:0] bus_addr;
    logic       bus_ale;
    logic       bus_ds;
    logic       bus_rw;
    logic [7:0] bus_dout;
    logic [7:0] bus_oe;
    logic [7:0] bus_din;
    logic       ext_ack;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    pin_bus_interface #(
        .TIMEOUT_CYCLES(15),
        .TIMEOUT_DATA  (8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rdy     (rdy),
        .done    (done),
        .err     (err),
        .bus_addr(bus_addr),
        .bus_ale (bus_ale),
        .bus_ds  (bus_ds),
        .bus_rw  (bus_rw),
        .bus_dout(bus_dout),
        .bus_oe  (bus_oe),
        .bus_din (bus_din),
        .ext_ack (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic sb_pop(input string tag);
        exp_t x;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check({tag, "_rdata"}, rdata, x.rdata);
            check({tag, "_err"}, err, x.err);
        end
    endtask

    // Presents a request in IDLE and returns one cycle later in ADDR.
    task automatic start_xfer(input string tag, input logic r, input logic [7:0] a,
                              input logic [7:0] d);
        rw    = r;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        tick();
        req   = 1'b0;
        check({tag, "_addr_ale"}, bus_ale, 1);
        check({tag, "_addr_bus_addr"}, bus_addr, a);
        check({tag, "_addr_bus_rw"}, bus_rw, r);
        check({tag, "_addr_rdy"}, rdy, 0);
        check({tag, "_addr_oe"}, bus_oe, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_wait;
        int oe_cycles;

        rst = 1'b1; req = 1'b0; rw = 1'b1; addr = 8'h00; wdata = 8'h00;
        bus_din = 8'h00; ext_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy", rdy, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_bus_addr", bus_addr, 8'h00);
        check("rst_bus_dout", bus_dout, 8'h00);
        check("rst_bus_oe", bus_oe, 8'h00);
        check("rst_ale", bus_ale, 0);
        check("rst_ds", bus_ds, 0);
        check("rst_bus_rw", bus_rw, 1);

        // Read with ack in the first WAIT cycle: done three cycles after req.
        bus_din = 8'hA5;
        start_xfer("t1", 1'b1, 8'h3C, 8'h00);
        tick();
        check("t1_wait_ds", bus_ds, 1);
        check("t1_wait_oe", bus_oe, 8'h00);
        check("t1_wait_done", done, 0);
        ext_ack = 1'b1;
        push_exp(8'hA5, 1'b0);
        tick();
        check("t1_done", done, 1);
        check("t1_done_ds", bus_ds, 0);
        check("t1_done_oe", bus_oe, 8'h00);
        sb_pop("t1");

        // Ack left high into a back-to-back read: ADDR must hold until it drops.
        tick();
        check("t4_idle_rdy", rdy, 1);
        check("t4_idle_done", done, 0);
        bus_din = 8'hC3;
        start_xfer("t4", 1'b1, 8'h77, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_ale", bus_ale, 1);
            check("t4_hold_done", done, 0);
        end
        ext_ack = 1'b0;
        tick();
        check("t4_wait_ds", bus_ds, 1);
        ext_ack = 1'b1;
        push_exp(8'hC3, 1'b0);
        tick();
        check("t4_done", done, 1);
        sb_pop("t4");
        ext_ack = 1'b0;
        tick();

        // Write with ack on the third WAIT cycle; req and addr wiggle mid-transfer.
        start_xfer("t2", 1'b0, 8'h10, 8'h5A);
        tick();
        oe_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_oe === 8'hFF && bus_dout === 8'h5A) oe_cycles++;
            check("t2_wait_bus_addr", bus_addr, 8'h10);
            check("t2_wait_ds", bus_ds, 1);
            if (i == 0) begin
                addr = 8'hEE; wdata = 8'h11; req = 1'b1;
            end else if (i == 1) begin
                req = 1'b0;
            end else begin
                ext_ack = 1'b1;
                push_exp(8'hC3, 1'b0);
            end
            tick();
        end
        check("t2_done", done, 1);
        check("t2_done_oe", bus_oe, 8'h00);
        check("t2_oe_cycles", oe_cycles, 3);
        sb_pop("t2");
        ext_ack = 1'b0;
        tick();
        check("t6_idle_rdy", rdy, 1);
        tick();
        check("t6_no_extra_rdy", rdy, 1);
        check("t6_no_extra_ale", bus_ale, 0);
        check("t6_bus_addr", bus_addr, 8'h10);

        // Read with no ack: timeout after exactly 15 WAIT cycles.
        start_xfer("t3", 1'b1, 8'h55, 8'h00);
        tick();
        push_exp(8'hFF, 1'b1);
        n_wait = 0;
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            if (bus_ds === 1'b1) n_wait++;
            tick();
        end
        check("t3_done", done, 1);
        check("t3_wait_cycles", n_wait, 15);
        check("t3_ds_fell", bus_ds, 0);
        sb_pop("t3");
        tick();
        check("t3_err_pulse", err, 0);
        check("t3_done_pulse", done, 0);

        // Ack arriving on the same cycle the timeout would fire: ack wins.
        start_xfer("t7", 1'b1, 8'h66, 8'h00);
        tick();
        repeat (14) tick();
        check("t7_still_wait", bus_ds, 1);
        bus_din = 8'h3E;
        ext_ack = 1'b1;
        push_exp(8'h3E, 1'b0);
        tick();
        check("t7_done", done, 1);
        sb_pop("t7");
        ext_ack = 1'b0;
        tick();

        // Reset in the middle of a write's WAIT phase.
        start_xfer("t5", 1'b0, 8'h20, 8'h99);
        tick();
        tick();
        check("t5_wait_oe", bus_oe, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rdy", rdy, 1);
        check("t5_oe", bus_oe, 8'h00);
        check("t5_rdata", rdata, 8'h00);
        check("t5_done", done, 0);
        check("t5_err", err, 0);
        check("t5_bus_addr", bus_addr, 8'h00);
        check("t5_bus_dout", bus_dout, 8'h00);
        check("t5_bus_rw", bus_rw, 1);
        check("t5_ds", bus_ds, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t5_quiet_done", done, 0);
            check("t5_quiet_rdy", rdy, 1);
        end

        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
